// File: rtl/ones_counter.sv
// Counts cycles with data high; count is registered, one cycle after the sampled bit.
// No handshake or backpressure: every rising edge out of reset is evaluated.
module ones_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Unsigned add truncated to WIDTH bits, so the top value wraps to zero.
    always_comb begin
        count_d = count_q;
        if (data) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_ones_counter.sv
// Directed bench for ones_counter: inputs change on the falling edge, count sampled 1 ns after the rising edge.
module tb_ones_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             data;
    logic [WIDTH-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    ones_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: count=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive data on the falling edge, then check count just after the next rising edge.
    task automatic step(input logic d, input int exp, input string tag);
        @(negedge clk);
        data = d;
        @(posedge clk);
        #1;
        check(tag, 16'(count), 16'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        data  = 1'b0;
        #1;
        check("reset_async", 16'(count), 16'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    bit pat_m[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int exp_m[7] = '{1, 1, 2, 3, 3, 3, 4};

    initial begin
        reset = 1'b0;
        data  = 1'b0;

        // Reset held low for two cycles, then idle
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", 16'(count), 16'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 0, "idle");

        // Continuous ones
        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1, i, "cont_ones");

        // Mixed pattern
        do_reset();
        for (int i = 0; i < 7; i++) step(pat_m[i], exp_m[i], "mixed");

        // Wrap-around: 15 at edge 15, 0 at edge 16, 1 at edge 17
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, i % 16, "wrap");

        // Asynchronous reset 2 ns after a rising edge, with count at 6
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, i, "pre_async");
        #1;
        reset = 1'b0;
        #1;
        check("async_clear", 16'(count), 16'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            data = 1'b1;
            @(posedge clk);
            #1;
            check("async_held", 16'(count), 16'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        data  = 1'b1;
        @(posedge clk);
        #1;
        check("async_release", 16'(count), 16'd1);

        // Hold at 9, also checked mid-cycle for glitches
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, i, "pre_hold");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 9, "hold_edge");
            #3;
            check("hold_mid", 16'(count), 16'd9);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
